player_lives: RTL

- Tracks the player's remaining lives from collision hits and extra-life pickups.
- Enforces a frame-counted invulnerability window after each hit, during which the player sprite blinks.
- Sits directly upstream of the game-over overlay stage, which consumes p_lives and latches game over when it reaches 0.
- player_visible gates the player sprite's display-on term in the pixel mux.

---
 rtl/player_lives.sv | 109 ++++++++++
 1 files changed

// File: rtl/player_lives.sv
// Player life counter with post-hit invulnerability window and sprite blink.
// Feeds p_lives to the game-over overlay and player_visible to the pixel mux.
module player_lives #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       extra_life,
  output logic [1:0] p_lives,
  output logic       invuln,
  output logic       player_visible,
  output logic       life_lost
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] INV_INIT   = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_INIT = CNT_W'(BLINK_FRAMES);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] inv_cnt_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic [1:0]       lives_inc_c;
  logic [1:0]       lives_hit_c;

  // Saturating lives arithmetic; a hit with a simultaneous pickup nets to zero.
  always_comb begin
    lives_inc_c = (p_lives == 2'd3) ? 2'd3 : p_lives + 2'd1;
    lives_hit_c = p_lives;
    if (!extra_life) begin
      lives_hit_c = (p_lives == 2'd0) ? 2'd0 : p_lives - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ALIVE;
      p_lives        <= LIVES_INIT;
      invuln         <= 1'b0;
      player_visible <= 1'b1;
      life_lost      <= 1'b0;
      inv_cnt_q      <= '0;
      blink_cnt_q    <= '0;
    end else begin
      life_lost <= 1'b0;
      case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            p_lives        <= lives_hit_c;
            life_lost      <= 1'b1;
            player_visible <= 1'b0;
            if (lives_hit_c == 2'd0) begin
              state_q <= ST_DEAD;
            end else begin
              // The coincident frame_tick is deliberately not counted here.
              state_q     <= ST_INVULN;
              invuln      <= 1'b1;
              inv_cnt_q   <= INV_INIT;
              blink_cnt_q <= BLINK_INIT;
            end
          end else if (extra_life) begin
            p_lives <= lives_inc_c;
          end
        end
        ST_INVULN: begin
          if (extra_life) begin
            p_lives <= lives_inc_c;
          end
          if (frame_tick) begin
            if (inv_cnt_q == CNT_W'(1)) begin
              state_q        <= ST_ALIVE;
              invuln         <= 1'b0;
              player_visible <= 1'b1;
              inv_cnt_q      <= '0;
              blink_cnt_q    <= '0;
            end else begin
              inv_cnt_q <= inv_cnt_q - CNT_W'(1);
              if (blink_cnt_q == CNT_W'(1)) begin
                player_visible <= ~player_visible;
                blink_cnt_q    <= BLINK_INIT;
              end else begin
                blink_cnt_q <= blink_cnt_q - CNT_W'(1);
              end
            end
          end
        end
        ST_DEAD: begin
          p_lives        <= 2'd0;
          player_visible <= 1'b0;
          invuln         <= 1'b0;
        end
        default: begin
          state_q <= ST_ALIVE;
        end
      endcase
    end
  end

endmodule
